spi_p_arbiter: RTL and testbench
================================

# spi_p_arbiter

Round-robin arbiter and transaction sequencer that shares one SPI master among `NUM_REQ` on-chip requesters. It sits in front of the SPI master's `start`/`busy`/`done`/`data_out`/`data_in` port. It grants one requester at a time, issues a single-cycle start, waits for completion or timeout, and returns the received word with a one-hot acknowledge or error pulse.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_BITS`, 8: SPI word width; matches the SPI master.
- `TIMEOUT_CYCLES`, 1024: maximum cycles to wait for `m_done`; 0 disables the timeout.
- `clk` in 1: system clock, single clock domain.
- `reset` in 1: synchronous, active-high.
- `req` in NUM_REQ: per-requester level request.
- `wdata` in NUM_REQ*DATA_BITS: flat write words; requester i owns bits [i*DATA_BITS +: DATA_BITS].
- `ack` out NUM_REQ: one-hot, one-cycle pulse; transfer completed.
- `err` out NUM_REQ: one-hot, one-cycle pulse; transfer timed out.
- `rdata` out DATA_BITS: received word, valid while `ack` or `err` is high.
- `grant_id` out $clog2(NUM_REQ): index of the current or most recent owner.
- `active` out 1: high from grant until the ack/err cycle inclusive.
- `m_start` out 1: start pulse to the SPI master.
- `m_data_out` out DATA_BITS: word to the SPI master.
- `m_busy` in 1: SPI master busy.
- `m_done` in 1: SPI master one-cycle done pulse.
- `m_data_in` in DATA_BITS: word from the SPI master, valid with `m_done`.

## Operation
- FSM states: IDLE, START, WAIT, RESP. All outputs are registered.
- IDLE: if any `req` bit is high and `m_busy` is low, select the winner by round-robin.
  - Search begins at `last+1` mod NUM_REQ, wrapping.
  - Latch the winner index into `grant_id` and the winner's `wdata` slice into `m_data_out`.
  - Go to START.
  - If `m_busy` is high, hold in IDLE.
- START: `m_start`=1 for exactly this one cycle. Clear the timeout counter. Go to WAIT.
- WAIT: on `m_done`, capture `m_data_in` into `rdata` and go to RESP with success.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT_CYCLES (nonzero), set `rdata`=0 and go to RESP with error.
  - If `m_done` and timeout occur in the same cycle, `m_done` wins.
- RESP: `ack[grant_id]`=1 or `err[grant_id]`=1 for one cycle. Update `last`=`grant_id`. Go to IDLE.
- Requester rules:
  - Hold `req` and `wdata` stable until `ack` or `err`; deassert `req` in the cycle after.
  - `wdata` is sampled only at grant; later changes have no effect.
  - A `req` dropped after grant does not abort the transfer; the ack or err is still issued.
  - A `req` dropped before grant is simply not served.
- `m_done` outside WAIT is ignored.
- The counter saturates and never wraps; its width is $clog2(TIMEOUT_CYCLES+1).

## Timing
- Reset values:
  - state = IDLE, `last` = NUM_REQ-1, so requester 0 is searched first.
  - `ack`, `err`, `m_start`, `active` = 0.
  - `rdata`, `m_data_out`, `grant_id` = 0.
- Reset mid-transfer returns to IDLE in the next cycle with no ack or err. The SPI master is reset by the same `reset`.
- Grant latency: `req` high in IDLE in cycle T gives START (`m_start`=1) in cycle T+1, and WAIT from T+2.
- Completion latency: `m_done` in cycle D gives `ack`/`rdata` in cycle D+1, and IDLE in D+2.
- Back-to-back:
  - Earliest next `m_start` is D+3.
  - Each requester gets at most one transfer per NUM_REQ grants while others are pending.
- `active` is high from cycle T+1 through the RESP cycle inclusive.

## Test plan
- Single request: NUM_REQ=4, DATA_BITS=8, mock master returns `m_done` 20 cycles after `m_start` with `m_data_in`=8'h3C. `req`=4'b0100, `wdata` slice 2 = 8'hA5. Required:
  - `m_start` exactly one cycle, with `m_data_out`=8'hA5.
  - `ack`=4'b0100 and `rdata`=8'h3C one cycle after `m_done`.
- Round-robin: `req`=4'b1111 held, each requester dropping its `req` after its ack. Grant order is 0,1,2,3. Then re-raise 4'b1001 with `last`=3: grant order is 0 then 3.
- Fairness under contention: `req`=4'b0011 held continuously, re-asserted immediately after each ack, for 6 transfers. Grants alternate 0,1,0,1,0,1.
- Timeout: TIMEOUT_CYCLES=16, mock never asserts `m_done`. Required:
  - `err` pulses one-hot for the owner 17 cycles after the START cycle, with `rdata`=0.
  - No `ack` pulse; next request is served normally.
- Busy and collision:
  - `m_busy`=1 held for 5 cycles with `req` pending: no `m_start` until `m_busy` falls.
  - `m_done` in the same cycle as timeout: `ack`, not `err`.
- Reset mid-WAIT: assert `reset` 10 cycles into WAIT. Required:
  - All outputs 0 next cycle; no ack or err.
  - First grant after reset goes to requester 0 when `req`=4'b1111.

Source files
------------

// File: rtl/spi_p_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one SPI master
// among NUM_REQ requesters: grant, single-cycle start, wait for done or
// timeout, then a one-hot ack/err pulse carrying the received word.
module spi_p_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DATA_BITS      = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*DATA_BITS-1:0]   wdata,
   output logic [NUM_REQ-1:0]             ack,
   output logic [NUM_REQ-1:0]             err,
   output logic [DATA_BITS-1:0]           rdata,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id,
   output logic                           active,
   output logic                           m_start,
   output logic [DATA_BITS-1:0]           m_data_out,
   input  logic                           m_busy,
   input  logic                           m_done,
   input  logic [DATA_BITS-1:0]           m_data_in
);

   localparam int unsigned ID_W  = $clog2(NUM_REQ);
   // A zero timeout still needs a legal one-bit counter.
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   state_t                 state, state_n;
   logic [ID_W-1:0]        last, last_n;
   logic [ID_W-1:0]        grant_n;
   logic [DATA_BITS-1:0]   dout_n;
   logic [DATA_BITS-1:0]   rdata_n;
   logic [NUM_REQ-1:0]     ack_n, err_n;
   logic                   start_n, active_n;
   logic [CNT_W-1:0]       cnt, cnt_n;
   logic                   found;
   logic [ID_W-1:0]        win;
   int unsigned            pos;
   logic [DATA_BITS-1:0]   words [NUM_REQ];

   // Split the flat write bus into one word per requester.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
      assign words[g] = wdata[g*DATA_BITS +: DATA_BITS];
   end

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last       <= ID_W'(NUM_REQ - 1);
         grant_id   <= '0;
         m_data_out <= '0;
         m_start    <= 1'b0;
         active     <= 1'b0;
         ack        <= '0;
         err        <= '0;
         rdata      <= '0;
         cnt        <= '0;
      end else begin
         state      <= state_n;
         last       <= last_n;
         grant_id   <= grant_n;
         m_data_out <= dout_n;
         m_start    <= start_n;
         active     <= active_n;
         ack        <= ack_n;
         err        <= err_n;
         rdata      <= rdata_n;
         cnt        <= cnt_n;
      end
   end

   // Round-robin winner search, next state and next output values.
   always_comb begin
      state_n  = state;
      last_n   = last;
      grant_n  = grant_id;
      dout_n   = m_data_out;
      start_n  = 1'b0;
      active_n = active;
      ack_n    = '0;
      err_n    = '0;
      rdata_n  = rdata;
      cnt_n    = cnt;
      found    = 1'b0;
      win      = last;
      pos      = 0;

      // Search starts just after the most recent owner and wraps.
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         pos = (32'(last) + k) % NUM_REQ;
         if (!found && req[ID_W'(pos)]) begin
            found = 1'b1;
            win   = ID_W'(pos);
         end
      end

      case (state)
         IDLE: begin
            if (found && !m_busy) begin
               state_n  = START;
               grant_n  = win;
               dout_n   = words[win];
               start_n  = 1'b1;
               active_n = 1'b1;
            end
         end
         START: begin
            state_n = WAIT;
            cnt_n   = '0;
         end
         WAIT: begin
            // A done arriving with the timeout still counts as success.
            if (m_done) begin
               rdata_n        = m_data_in;
               ack_n[grant_id] = 1'b1;
               state_n        = RESP;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
               rdata_n        = '0;
               err_n[grant_id] = 1'b1;
               state_n        = RESP;
            end else if (cnt != CNT_MAX) begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         RESP: begin
            last_n   = grant_id;
            active_n = 1'b0;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_p_arbiter.sv
// Directed self-checking bench for spi_p_arbiter: a default-timeout instance
// driven by a mock SPI master, plus a 16-cycle-timeout instance driven by hand.
module tb_spi_p_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]  words [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};
   logic [31:0] wdata;
   assign wdata = {words[3], words[2], words[1], words[0]};

   // Default-timeout instance.
   logic [3:0] req = '0, ack, err;
   logic [7:0] rdata, m_data_out, m_data_in = '0;
   logic [1:0] grant_id;
   logic       active, m_start, m_busy = 1'b0, m_done = 1'b0;

   // 16-cycle-timeout instance.
   logic [3:0] req16 = '0, ack16, err16;
   logic [7:0] rdata16, m_data_out16, m_data_in16 = '0;
   logic [1:0] grant_id16;
   logic       active16, m_start16, m_busy16 = 1'b0, m_done16 = 1'b0;

   int vec = 0;
   int miss = 0;

   int         lat = 20;
   bit         mock_en = 1'b1;
   logic [7:0] mock_data = 8'h3C;
   int         mcnt = 0;

   spi_p_arbiter #(.NUM_REQ(4), .DATA_BITS(8)) u_dut (
      .clk(clk), .reset(reset), .req(req), .wdata(wdata),
      .ack(ack), .err(err), .rdata(rdata), .grant_id(grant_id), .active(active),
      .m_start(m_start), .m_data_out(m_data_out),
      .m_busy(m_busy), .m_done(m_done), .m_data_in(m_data_in)
   );

   spi_p_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .TIMEOUT_CYCLES(16)) u_dut16 (
      .clk(clk), .reset(reset), .req(req16), .wdata(wdata),
      .ack(ack16), .err(err16), .rdata(rdata16), .grant_id(grant_id16), .active(active16),
      .m_start(m_start16), .m_data_out(m_data_out16),
      .m_busy(m_busy16), .m_done(m_done16), .m_data_in(m_data_in16)
   );

   // Mock SPI master: done pulse `lat` cycles after the start cycle.
   always @(posedge clk) begin
      #1;
      m_done = 1'b0;
      if (reset) mcnt = 0;
      else if (m_start && mock_en) mcnt = lat;
      else if (mcnt > 0) begin
         mcnt--;
         if (mcnt == 0) begin
            m_done    = 1'b1;
            m_data_in = mock_data;
         end
      end
   end

   task automatic wait_start(input bit sel, input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = sel ? m_start16 : m_start;
      end
   endtask

   task automatic wait_resp(input bit sel, input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = sel ? ((ack16 | err16) != 4'b0) : ((ack | err) != 4'b0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req = '0; req16 = '0; m_busy = 1'b0;
      repeat (3) @(negedge clk);
      vec++; if ({ack, err, m_start, active, rdata, m_data_out, grant_id} !== 28'h0) begin
         miss++; $display("FAIL reset_main: got %h want 0", {ack, err, m_start, active, rdata, m_data_out, grant_id});
      end
      vec++; if ({ack16, err16, m_start16, active16, rdata16, m_data_out16, grant_id16} !== 28'h0) begin
         miss++; $display("FAIL reset_t16: got %h want 0", {ack16, err16, m_start16, active16, rdata16, m_data_out16, grant_id16});
      end
      reset = 1'b0;
      @(negedge clk);
      vec++; if ({m_start, active} !== 2'b00) begin
         miss++; $display("FAIL idle_after_reset: got %b want 00", {m_start, active});
      end
   endtask

   task automatic test_single();
      bit seen, got;
      int t, s, nstart;
      lat = 20; mock_data = 8'h3C; mock_en = 1'b1;
      req = 4'b0100; t = cyc;
      wait_start(1'b0, 10, seen);
      s = cyc;
      vec++; if (!seen || (s - t) != 1) begin
         miss++; $display("FAIL grant_latency: got seen=%0d lat=%0d want 1", seen, s - t);
      end
      vec++; if (m_data_out !== 8'hA5) begin
         miss++; $display("FAIL single_dout: got %h want a5", m_data_out);
      end
      vec++; if (grant_id !== 2'd2 || active !== 1'b1) begin
         miss++; $display("FAIL single_grant: got id=%0d active=%b want 2/1", grant_id, active);
      end
      nstart = 1; got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (m_start) nstart++;
         got = ((ack | err) != 4'b0);
      end
      req = '0;
      vec++; if (!got || cyc != s + 21) begin
         miss++; $display("FAIL single_ack_time: got seen=%0d offset=%0d want 21", got, cyc - s);
      end
      vec++; if (ack !== 4'b0100 || err !== 4'b0000) begin
         miss++; $display("FAIL single_ack: got ack=%b err=%b want 0100/0000", ack, err);
      end
      vec++; if (rdata !== 8'h3C || active !== 1'b1) begin
         miss++; $display("FAIL single_rdata: got %h active=%b want 3c/1", rdata, active);
      end
      vec++; if (nstart != 1) begin
         miss++; $display("FAIL single_start_count: got %0d want 1", nstart);
      end
      @(negedge clk);
      vec++; if ({ack, active, m_start} !== 6'b0) begin
         miss++; $display("FAIL single_release: got %b want 0", {ack, active, m_start});
      end
   endtask

   task automatic test_round_robin();
      bit seen, got;
      int ord [2] = '{0, 3};
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0; lat = 3; mock_data = 8'h5E;
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_start(1'b0, 20, seen);
         vec++; if (!seen || grant_id !== 2'(k) || m_data_out !== words[k]) begin
            miss++; $display("FAIL rr_grant%0d: got seen=%0d id=%0d dout=%h want %0d/%h", k, seen, grant_id, m_data_out, k, words[k]);
         end
         wait_resp(1'b0, 20, got);
         vec++; if (!got || ack !== 4'(1 << k)) begin
            miss++; $display("FAIL rr_ack%0d: got %b want %b", k, ack, 4'(1 << k));
         end
         req[k] = 1'b0;
      end
      @(negedge clk);
      req = 4'b1001;
      for (int k = 0; k < 2; k++) begin
         wait_start(1'b0, 20, seen);
         vec++; if (!seen || grant_id !== 2'(ord[k])) begin
            miss++; $display("FAIL rr_wrap%0d: got seen=%0d id=%0d want %0d", k, seen, grant_id, ord[k]);
         end
         wait_resp(1'b0, 20, got);
         req[ord[k]] = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      bit seen, got;
      int prev_ack;
      prev_ack = 0;
      @(negedge clk);
      req = 4'b0011;
      for (int k = 0; k < 6; k++) begin
         wait_start(1'b0, 20, seen);
         vec++; if (!seen || grant_id !== 2'(k % 2)) begin
            miss++; $display("FAIL fair_grant%0d: got seen=%0d id=%0d want %0d", k, seen, grant_id, k % 2);
         end
         if (k > 0) begin
            vec++; if (cyc != prev_ack + 2) begin
               miss++; $display("FAIL b2b_gap%0d: got %0d want 2", k, cyc - prev_ack);
            end
         end
         wait_resp(1'b0, 20, got);
         vec++; if (!got || ack !== ((k % 2 == 1) ? 4'b0010 : 4'b0001)) begin
            miss++; $display("FAIL fair_ack%0d: got %b", k, ack);
         end
         prev_ack = cyc;
      end
      req = '0;
   endtask

   task automatic test_timeout();
      bit seen, got;
      int s;
      req16 = 4'b0010;
      wait_start(1'b1, 10, seen);
      s = cyc;
      wait_resp(1'b1, 40, got);
      req16 = '0;
      vec++; if (!seen || !got || cyc != s + 17) begin
         miss++; $display("FAIL timeout_time: got seen=%0d/%0d offset=%0d want 17", seen, got, cyc - s);
      end
      vec++; if (err16 !== 4'b0010 || ack16 !== 4'b0000 || rdata16 !== 8'h00) begin
         miss++; $display("FAIL timeout_err: got err=%b ack=%b rdata=%h want 0010/0000/00", err16, ack16, rdata16);
      end
      @(negedge clk);
      req16 = 4'b0001;
      wait_start(1'b1, 10, seen);
      vec++; if (!seen || grant_id16 !== 2'd0) begin
         miss++; $display("FAIL after_timeout_grant: got seen=%0d id=%0d want 0", seen, grant_id16);
      end
      repeat (5) @(negedge clk);
      m_done16 = 1'b1; m_data_in16 = 8'h5A;
      @(negedge clk);
      m_done16 = 1'b0; req16 = '0;
      vec++; if (ack16 !== 4'b0001 || err16 !== 4'b0000 || rdata16 !== 8'h5A) begin
         miss++; $display("FAIL after_timeout_ack: got ack=%b err=%b rdata=%h want 0001/0000/5a", ack16, err16, rdata16);
      end
   endtask

   task automatic test_collision();
      bit seen;
      @(negedge clk);
      req16 = 4'b0100;
      wait_start(1'b1, 10, seen);
      repeat (16) @(negedge clk);
      m_done16 = 1'b1; m_data_in16 = 8'h77;
      @(negedge clk);
      m_done16 = 1'b0; req16 = '0;
      vec++; if (!seen || ack16 !== 4'b0100 || err16 !== 4'b0000 || rdata16 !== 8'h77) begin
         miss++; $display("FAIL collision: got ack=%b err=%b rdata=%h want 0100/0000/77", ack16, err16, rdata16);
      end
   endtask

   task automatic test_busy();
      bit seen, got;
      int b;
      @(negedge clk);
      m_busy = 1'b1; req = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vec++; if (m_start !== 1'b0) begin
            miss++; $display("FAIL busy_hold%0d: got m_start=%b want 0", i, m_start);
         end
      end
      m_busy = 1'b0; b = cyc;
      wait_start(1'b0, 10, seen);
      vec++; if (!seen || cyc != b + 1 || grant_id !== 2'd0) begin
         miss++; $display("FAIL busy_release: got seen=%0d offset=%0d id=%0d want 1/0", seen, cyc - b, grant_id);
      end
      wait_resp(1'b0, 20, got);
      req = '0;
      vec++; if (!got || ack !== 4'b0001) begin
         miss++; $display("FAIL busy_ack: got %b want 0001", ack);
      end
   endtask

   task automatic test_reset_mid_wait();
      bit seen, got;
      @(negedge clk);
      mock_en = 1'b0; req = 4'b1111;
      wait_start(1'b0, 10, seen);
      vec++; if (!seen || grant_id !== 2'd1) begin
         miss++; $display("FAIL pre_reset_grant: got seen=%0d id=%0d want 1", seen, grant_id);
      end
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      vec++; if ({ack, err, m_start, active, rdata, m_data_out, grant_id} !== 28'h0) begin
         miss++; $display("FAIL mid_wait_reset: got %h want 0", {ack, err, m_start, active, rdata, m_data_out, grant_id});
      end
      mock_en = 1'b1; lat = 4; mock_data = 8'hC3;
      reset = 1'b0;
      wait_start(1'b0, 10, seen);
      vec++; if (!seen || grant_id !== 2'd0 || m_data_out !== 8'h11) begin
         miss++; $display("FAIL post_reset_grant: got seen=%0d id=%0d dout=%h want 0/11", seen, grant_id, m_data_out);
      end
      wait_resp(1'b0, 20, got);
      req = '0;
      vec++; if (!got || ack !== 4'b0001 || rdata !== 8'hC3) begin
         miss++; $display("FAIL post_reset_ack: got ack=%b rdata=%h want 0001/c3", ack, rdata);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_back_to_back();
      test_timeout();
      test_collision();
      test_busy();
      test_reset_mid_wait();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
